// File: rtl/cache_controller_nway.sv
// N-way set-associative L1 cache controller: lookup, victim selection, writeback/allocate/invalidate over ACE.
// Optional transaction watchdog compiled in with CACHE_CTRL_ACE_TIMEOUT_EN.

module cache_way_decode #(
  parameter int WIDTH_STATE = 3
) (
  input  logic                   hit,
  input  logic [WIDTH_STATE-1:0] state,
  output logic                   eff_hit,
  output logic                   is_inv,
  output logic                   is_dirty,
  output logic                   is_unique
);
  localparam logic [WIDTH_STATE-1:0] ST_UC = WIDTH_STATE'(0);
  localparam logic [WIDTH_STATE-1:0] ST_UD = WIDTH_STATE'(1);
  localparam logic [WIDTH_STATE-1:0] ST_SD = WIDTH_STATE'(3);

  // valid encodings occupy 0..3, so everything above SD reads as I
  assign is_inv    = (state > ST_SD);
  assign eff_hit   = hit && !is_inv;
  assign is_dirty  = (state == ST_UD) || (state == ST_SD);
  assign is_unique = (state == ST_UC) || (state == ST_UD);
endmodule

module cache_controller_nway #(
  parameter int WIDTH_STATE    = 3,
  parameter int NUM_WAYS       = 4,
  parameter int WAY_W          = $clog2(NUM_WAYS),
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [1:0]                      cpu_request,
  input  logic [NUM_WAYS-1:0]             way_hit,
  input  logic [NUM_WAYS*WIDTH_STATE-1:0] way_state,
  input  logic                            ace_ready,
  input  logic                            ace_shared,
  output logic                            read_req,
  output logic                            write_req,
  output logic                            invalid_req,
  output logic                            write_from_cpu,
  output logic                            write_from_interconnect,
  output logic                            state_sel,
  output logic [WIDTH_STATE-1:0]          new_state,
  output logic [WAY_W-1:0]                way_sel,
  output logic                            cache_complete,
  output logic                            cache_ready,
  output logic                            cache_error
);
  localparam logic [WIDTH_STATE-1:0] ST_UC = WIDTH_STATE'(0);
  localparam logic [WIDTH_STATE-1:0] ST_UD = WIDTH_STATE'(1);
  localparam logic [WIDTH_STATE-1:0] ST_SC = WIDTH_STATE'(2);
  localparam logic [WIDTH_STATE-1:0] ST_SD = WIDTH_STATE'(3);

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WRITEBACK, S_ALLOCATE, S_INVALIDATE} fsm_t;

  typedef struct packed {
    logic read_req;
    logic write_req;
    logic invalid_req;
    logic wr_cpu;
    logic wr_ic;
    logic state_sel;
    logic complete;
    logic ready;
    logic error;
  } ctl_t;

  fsm_t                                 state_q, state_d;
  logic                                 op_write_q, op_write_d;
  logic [WAY_W-1:0]                     tgt_way_q, tgt_way_d;
  logic [WAY_W-1:0]                     rr_ptr_q, rr_ptr_d;
  logic [NUM_WAYS-1:0][WIDTH_STATE-1:0] st;
  logic [NUM_WAYS-1:0]                  eff_hit, is_inv, is_dirty, is_unique;
  logic                                 any_hit, any_inv;
  logic [WAY_W-1:0]                     hit_way, inv_way, victim;
  logic                                 timeout;
  ctl_t                                 ctl;

  assign st = way_state;

  cache_way_decode #(.WIDTH_STATE(WIDTH_STATE)) u_way [NUM_WAYS-1:0] (
    .hit       (way_hit),
    .state     (st),
    .eff_hit   (eff_hit),
    .is_inv    (is_inv),
    .is_dirty  (is_dirty),
    .is_unique (is_unique)
  );

  // lowest-index priority for both the hit way and the first invalid way
  always_comb begin
    any_hit = |eff_hit;
    any_inv = |is_inv;
    hit_way = '0;
    inv_way = '0;
    for (int k = NUM_WAYS-1; k >= 0; k--) begin
      if (eff_hit[k]) hit_way = WAY_W'(k);
      if (is_inv[k])  inv_way = WAY_W'(k);
    end
  end

  assign victim = any_inv ? inv_way : rr_ptr_q;

`ifdef CACHE_CTRL_ACE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wd_cnt_q;
  logic             wait_st;

  assign wait_st = (state_q == S_WRITEBACK) || (state_q == S_ALLOCATE) || (state_q == S_INVALIDATE);
  assign timeout = wait_st && (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     wd_cnt_q <= '0;
    else if (state_d != state_q)    wd_cnt_q <= '0;
    else if (wait_st && !ace_ready) wd_cnt_q <= wd_cnt_q + 1'b1;
  end
`else
  // watchdog compiled out: the comparison is constant false
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      op_write_q <= 1'b0;
      tgt_way_q  <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_write_q <= op_write_d;
      tgt_way_q  <= tgt_way_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_write_d = op_write_q;
    tgt_way_d  = tgt_way_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      S_IDLE: if (!cpu_request[1]) begin
        op_write_d = cpu_request[0];
        state_d    = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (any_hit) begin
          if (op_write_q && !is_unique[hit_way]) begin
            tgt_way_d = hit_way;
            state_d   = S_INVALIDATE;
          end else begin
            state_d   = S_IDLE;
          end
        end else begin
          tgt_way_d = victim;
          if (!any_inv) rr_ptr_d = rr_ptr_q + 1'b1;
          state_d   = is_dirty[victim] ? S_WRITEBACK : S_ALLOCATE;
        end
      end
      S_WRITEBACK:  if (timeout) state_d = S_IDLE; else if (ace_ready) state_d = S_ALLOCATE;
      S_ALLOCATE:   if (timeout) state_d = S_IDLE; else if (ace_ready) state_d = S_LOOKUP;
      S_INVALIDATE: if (timeout || ace_ready) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ctl       = '0;
    new_state = '0;
    way_sel   = tgt_way_q;
    if (timeout) begin
      ctl.error    = 1'b1;
      ctl.complete = 1'b1;
      ctl.ready    = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: ctl.ready = 1'b1;
        S_LOOKUP: begin
          way_sel = '0;
          if (any_hit) begin
            if (!op_write_q) begin
              way_sel      = hit_way;
              ctl.complete = 1'b1;
              ctl.ready    = 1'b1;
            end else if (is_unique[hit_way]) begin
              way_sel       = hit_way;
              ctl.wr_cpu    = 1'b1;
              ctl.state_sel = 1'b1;
              new_state     = ST_UD;
              ctl.complete  = 1'b1;
              ctl.ready     = 1'b1;
            end else begin
              ctl.invalid_req = 1'b1;
            end
          end else if (is_dirty[victim]) begin
            ctl.write_req = 1'b1;
            ctl.state_sel = 1'b1;
            way_sel       = victim;
            new_state     = (st[victim] == ST_SD) ? ST_SC : ST_UC;
          end else begin
            ctl.read_req = 1'b1;
          end
        end
        S_WRITEBACK: begin
          if (ace_ready) ctl.read_req  = 1'b1;
          else           ctl.write_req = 1'b1;
        end
        S_ALLOCATE: begin
          if (ace_ready) begin
            ctl.wr_ic     = 1'b1;
            ctl.state_sel = 1'b1;
            new_state     = ace_shared ? ST_SC : ST_UC;
          end else begin
            ctl.read_req  = 1'b1;
          end
        end
        S_INVALIDATE: begin
          if (ace_ready) begin
            ctl.wr_cpu    = 1'b1;
            ctl.state_sel = 1'b1;
            new_state     = ST_UD;
            ctl.complete  = 1'b1;
            ctl.ready     = 1'b1;
          end else begin
            ctl.invalid_req = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign read_req                = ctl.read_req;
  assign write_req               = ctl.write_req;
  assign invalid_req             = ctl.invalid_req;
  assign write_from_cpu          = ctl.wr_cpu;
  assign write_from_interconnect = ctl.wr_ic;
  assign state_sel               = ctl.state_sel;
  assign cache_complete          = ctl.complete;
  assign cache_ready             = ctl.ready;
  assign cache_error             = ctl.error;
endmodule

// File: tb/tb_cache_controller_nway.sv
// Directed bench for cache_controller_nway: per-cycle behavioural model plus literal spot checks.
// The bench also plays the datapath, applying state writes and fills to its own way array.

module tb_cache_controller_nway;
  localparam int NW = 4;
  localparam int UC = 0, UD = 1, SC = 2, SD = 3, SI = 4;
`ifdef CACHE_CTRL_ACE_TIMEOUT_EN
  localparam int TO_CYC = 8;
`else
  localparam int TO_CYC = 256;
`endif
  localparam int P_IDLE = 0, P_LOOK = 1, P_WB = 2, P_ALLOC = 3, P_INV = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    cpu_request;
  logic [NW-1:0] hit_m;
  logic [NW*3-1:0] way_state;
  logic          ace_ready, ace_shared;
  logic          read_req, write_req, invalid_req, write_from_cpu, write_from_interconnect;
  logic          state_sel, cache_complete, cache_ready, cache_error;
  logic [2:0]    new_state;
  logic [1:0]    way_sel;
  int            st_m [NW];

  int n_chk = 0, n_fail = 0;
  int m_ph, m_tgt, m_rr, m_cnt, m_wr;
  int e_rd, e_wr, e_inv, e_wfc, e_wfi, e_ss, e_ns, e_ws, e_cc, e_cr, e_err;
  int dp_we = 0, dp_way = 0, dp_st = 0, dp_fill = 0;

  assign way_state = {st_m[3][2:0], st_m[2][2:0], st_m[1][2:0], st_m[0][2:0]};

  always #5 clk = ~clk;

  cache_controller_nway #(.WIDTH_STATE(3), .NUM_WAYS(NW), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk                     (clk),
    .reset                   (rst_n),
    .cpu_request             (cpu_request),
    .way_hit                 (hit_m),
    .way_state               (way_state),
    .ace_ready               (ace_ready),
    .ace_shared              (ace_shared),
    .read_req                (read_req),
    .write_req               (write_req),
    .invalid_req             (invalid_req),
    .write_from_cpu          (write_from_cpu),
    .write_from_interconnect (write_from_interconnect),
    .state_sel               (state_sel),
    .new_state               (new_state),
    .way_sel                 (way_sel),
    .cache_complete          (cache_complete),
    .cache_ready             (cache_ready),
    .cache_error             (cache_error)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour from the controller rules; also advances the model to the next cycle.
  task automatic model_check();
    int s [NW];
    int hw, vic, nph, ntgt, nrr, nwr;
    bit to;
    e_rd = 0; e_wr = 0; e_inv = 0; e_wfc = 0; e_wfi = 0; e_ss = 0;
    e_ns = 0; e_ws = 0; e_cc = 0; e_cr = 0; e_err = 0;
    if (!rst_n) begin
      m_ph = P_IDLE; m_tgt = 0; m_rr = 0; m_cnt = 0; m_wr = 0;
      e_cr = 1;
    end else begin
      for (int k = 0; k < NW; k++) s[k] = (st_m[k] > SD) ? SI : st_m[k];
      hw = -1;
      for (int k = 0; k < NW; k++) if (hw < 0 && hit_m[k] && s[k] != SI) hw = k;
      nph = m_ph; ntgt = m_tgt; nrr = m_rr; nwr = m_wr;
      e_ws = m_tgt;
      to = 1'b0;
`ifdef CACHE_CTRL_ACE_TIMEOUT_EN
      to = (m_ph >= P_WB) && (m_cnt == TO_CYC);
`endif
      if (to) begin
        e_err = 1; e_cc = 1; e_cr = 1; nph = P_IDLE;
      end else if (m_ph == P_IDLE) begin
        e_cr = 1;
        if (cpu_request < 2) begin nwr = cpu_request; nph = P_LOOK; end
      end else if (m_ph == P_LOOK) begin
        e_ws = 0;
        if (hw >= 0 && m_wr == 0) begin
          e_ws = hw; e_cc = 1; e_cr = 1; nph = P_IDLE;
        end else if (hw >= 0 && (s[hw] == UC || s[hw] == UD)) begin
          e_ws = hw; e_wfc = 1; e_ss = 1; e_ns = UD; e_cc = 1; e_cr = 1; nph = P_IDLE;
        end else if (hw >= 0) begin
          e_inv = 1; ntgt = hw; nph = P_INV;
        end else begin
          vic = -1;
          for (int k = 0; k < NW; k++) if (vic < 0 && s[k] == SI) vic = k;
          if (vic < 0) begin vic = m_rr; nrr = (m_rr + 1) % NW; end
          ntgt = vic;
          if (s[vic] == UD || s[vic] == SD) begin
            e_wr = 1; e_ss = 1; e_ws = vic; e_ns = s[vic] - 1; nph = P_WB;
          end else begin
            e_rd = 1; nph = P_ALLOC;
          end
        end
      end else if (m_ph == P_WB) begin
        if (ace_ready) begin e_rd = 1; nph = P_ALLOC; end
        else e_wr = 1;
      end else if (m_ph == P_ALLOC) begin
        if (ace_ready) begin e_wfi = 1; e_ss = 1; e_ns = ace_shared ? SC : UC; nph = P_LOOK; end
        else e_rd = 1;
      end else begin
        if (ace_ready) begin
          e_wfc = 1; e_ss = 1; e_ns = UD; e_cc = 1; e_cr = 1; nph = P_IDLE;
        end else e_inv = 1;
      end
      if (nph != m_ph) m_cnt = 0;
      else if (m_ph >= P_WB) m_cnt++;
      m_ph = nph; m_tgt = ntgt; m_rr = nrr; m_wr = nwr;
    end
    chk("read_req", read_req, e_rd);
    chk("write_req", write_req, e_wr);
    chk("invalid_req", invalid_req, e_inv);
    chk("write_from_cpu", write_from_cpu, e_wfc);
    chk("write_from_interconnect", write_from_interconnect, e_wfi);
    chk("state_sel", state_sel, e_ss);
    chk("new_state", new_state, e_ns);
    chk("way_sel", way_sel, e_ws);
    chk("cache_complete", cache_complete, e_cc);
    chk("cache_ready", cache_ready, e_cr);
    chk("cache_error", cache_error, e_err);
    dp_we = e_ss; dp_way = e_ws; dp_st = e_ns; dp_fill = e_wfi;
  endtask

  task automatic cyc();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
    if (dp_we != 0) begin
      st_m[dp_way] = dp_st;
      if (dp_fill != 0) hit_m[dp_way] = 1'b1;
      dp_we = 0;
    end
  endtask

  task automatic set_ways(input int a, input int b, input int c, input int d, input logic [NW-1:0] h);
    st_m[0] = a; st_m[1] = b; st_m[2] = c; st_m[3] = d; hit_m = h;
  endtask

  task automatic req(input logic [1:0] r);
    cpu_request = r;
    cyc();
    cpu_request = 2'b10;
  endtask

  initial begin
    rst_n = 1'b0; cpu_request = 2'b10; ace_ready = 1'b0; ace_shared = 1'b0;
    set_ways(SI, SI, SI, SI, '0);
    #1;
    chk("reset_ready", cache_ready, 1);
    chk("reset_way_sel", way_sel, 0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();

    // read hit on way 2
    set_ways(SC, UD, UC, SI, 4'b0100);
    req(2'b00); #1;
    chk("rd_hit_complete", cache_complete, 1);
    chk("rd_hit_way", way_sel, 2);
    chk("rd_hit_state_sel", state_sel, 0);
    cyc();
    // multiple hits resolve low; hit on an I-coded way is ignored
    set_ways(UC, SC, UC, SC, 4'b0110);
    req(2'b00); #1; chk("multi_hit_way", way_sel, 1); cyc();
    set_ways(6, SI, UD, SI, 4'b0101);
    req(2'b00); #1; chk("inv_hit_skip_way", way_sel, 2); cyc();
    ace_ready = 1'b1; cyc(); ace_ready = 1'b0; cyc();

    // write hit on shared dirty way 1 -> invalidate
    set_ways(UC, SD, SI, SI, 4'b0010);
    req(2'b01); #1; chk("wr_shared_inv_req", invalid_req, 1);
    cyc(); cyc();
    ace_ready = 1'b1; #1;
    chk("inv_done_state", new_state, UD);
    chk("inv_done_way", way_sel, 1);
    chk("inv_done_wfc", write_from_cpu, 1);
    chk("inv_done_complete", cache_complete, 1);
    cyc(); ace_ready = 1'b0; cyc();

    // read miss with way 3 invalid, shared fill
    set_ways(UC, SC, UC, SI, '0);
    req(2'b00); #1; chk("miss_read_req", read_req, 1);
    cyc();
    cpu_request = 2'b01; cyc(); cpu_request = 2'b10;
    ace_ready = 1'b1; ace_shared = 1'b1; #1;
    chk("fill_state", new_state, SC);
    chk("fill_way", way_sel, 3);
    chk("fill_wfi", write_from_interconnect, 1);
    cyc(); ace_ready = 1'b0; ace_shared = 1'b0; #1;
    chk("relookup_complete", cache_complete, 1);
    chk("relookup_way", way_sel, 3);
    cyc();

    // round-robin victims over two full laps
    for (int i = 0; i < 8; i++) begin
      set_ways(UC, SC, UC, SC, '0);
      req(2'b00); cyc();
      ace_ready = 1'b1; #1;
      chk("rr_victim", way_sel, i % NW);
      cyc(); ace_ready = 1'b0; cyc();
    end

    // dirty victim 0 (UD): writeback then allocate, write completes on re-lookup
    set_ways(UD, UC, SC, SC, '0);
    req(2'b01); #1;
    chk("wb_write_req", write_req, 1);
    chk("wb_new_state", new_state, UC);
    chk("wb_way", way_sel, 0);
    chk("wb_state_sel", state_sel, 1);
    cyc(); cyc();
    ace_ready = 1'b1; #1;
    chk("wb_end_read_req", read_req, 1);
    chk("wb_end_write_req", write_req, 0);
    cyc(); ace_ready = 1'b0; cyc();
    ace_ready = 1'b1; cyc(); ace_ready = 1'b0; #1;
    chk("dirty_miss_complete", cache_complete, 1);
    chk("dirty_miss_new_state", new_state, UD);
    cyc();

    // write miss with shared fill goes through invalidate
    set_ways(UC, SI, UC, UC, '0);
    req(2'b01); cyc();
    ace_ready = 1'b1; ace_shared = 1'b1; cyc();
    ace_ready = 1'b0; ace_shared = 1'b0; #1;
    chk("wr_miss_shared_inv", invalid_req, 1);
    cyc(); ace_ready = 1'b1; cyc(); ace_ready = 1'b0; cyc();

    // stalled allocate
    set_ways(UC, SI, UC, UC, '0);
    req(2'b00); cyc();
`ifdef CACHE_CTRL_ACE_TIMEOUT_EN
    repeat (7) cyc();
    #1; chk("to_not_yet", cache_error, 0);
    cyc(); #1;
    chk("to_error", cache_error, 1);
    chk("to_complete", cache_complete, 1);
    chk("to_read_req", read_req, 0);
    chk("to_state_sel", state_sel, 0);
    cyc(); #1;
    chk("to_idle_ready", cache_ready, 1);
    cyc();
`else
    repeat (10) cyc();
    #1;
    chk("stall_read_req", read_req, 1);
    chk("stall_no_error", cache_error, 0);
    ace_ready = 1'b1; cyc(); ace_ready = 1'b0; cyc(); cyc();
`endif

    // reset in the middle of a writeback
    set_ways(UD, UD, UD, UD, '0);
    req(2'b00); cyc(); cyc();
    rst_n = 1'b0; #1;
    chk("rst_mid_ready", cache_ready, 1);
    chk("rst_mid_write_req", write_req, 0);
    chk("rst_mid_read_req", read_req, 0);
    chk("rst_mid_state_sel", state_sel, 0);
    chk("rst_mid_way_sel", way_sel, 0);
    chk("rst_mid_complete", cache_complete, 0);
    cyc(); cyc();
    rst_n = 1'b1; cyc();
    set_ways(UC, UC, UC, UC, '0);
    req(2'b00); cyc(); #1;
    chk("post_rst_victim", way_sel, 0);
    ace_ready = 1'b1; cyc(); ace_ready = 1'b0; cyc(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
